// File: rtl/cmd_arbiter.sv
// cmd_arbiter: chooses between a host (SPI) command source and an internal
// sequencer. Each accepted command is issued to the decoder as a one-cycle
// strobe, followed by a fixed idle gap. The host wins ties unless the
// sequencer has been passed over STARVE_LIMIT times in a row.
module cmd_arbiter #(
  parameter int DATAWORD_WIDTH = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [7:0]                host_cmd,
  input  logic [DATAWORD_WIDTH-1:0] host_data,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [7:0]                seq_cmd,
  input  logic [DATAWORD_WIDTH-1:0] seq_data,
  input  logic                      seq_valid,
  output logic                      seq_ready,
  output logic [7:0]                cmd_word,
  output logic [DATAWORD_WIDTH-1:0] data_word,
  output logic                      cmd_valid,
  output logic                      grant_src,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [1:0]                state_reg,      state_next;
  logic [3:0]                starve_cnt_reg, starve_cnt_next;
  logic [3:0]                gap_cnt_reg,    gap_cnt_next;
  logic [7:0]                cmd_word_reg,   cmd_word_next;
  logic [DATAWORD_WIDTH-1:0] data_word_reg,  data_word_next;
  logic                      cmd_valid_reg,  cmd_valid_next;
  logic                      grant_src_reg,  grant_src_next;

  logic sel_seq;
  logic sel_host;
  logic accept_ok;

  // Source selection and ready generation; ready is forced low during reset
  always_comb begin
    sel_seq    = seq_valid && (!host_valid || (starve_cnt_reg >= STARVE_LIM));
    sel_host   = host_valid && !sel_seq;
    accept_ok  = rst_n && (state_reg == ST_IDLE);
    host_ready = accept_ok && sel_host;
    seq_ready  = accept_ok && sel_seq;
  end

  // Next-state, capture, starvation and gap counter logic
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    cmd_word_next   = cmd_word_reg;
    data_word_next  = data_word_reg;
    grant_src_next  = grant_src_reg;
    cmd_valid_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (seq_ready) begin
          cmd_word_next   = seq_cmd;
          data_word_next  = seq_data;
          grant_src_next  = 1'b1;
          cmd_valid_next  = 1'b1;
          starve_cnt_next = 4'd0;
          state_next      = ST_ISSUE;
        end else if (host_ready) begin
          cmd_word_next  = host_cmd;
          data_word_next = host_data;
          grant_src_next = 1'b0;
          cmd_valid_next = 1'b1;
          // Host passed the sequencer over: count it, saturating
          if (seq_valid && (starve_cnt_reg != 4'd15)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP_CYCLES > 0) begin
          gap_cnt_next = GAP_LOAD;
          state_next   = ST_GAP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        // Counter holds the cycles remaining including the current one
        if (gap_cnt_reg <= 4'd1) begin
          gap_cnt_next = 4'd0;
          state_next   = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        gap_cnt_next = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      starve_cnt_reg <= 4'd0;
      gap_cnt_reg    <= 4'd0;
      cmd_word_reg   <= 8'd0;
      data_word_reg  <= '0;
      cmd_valid_reg  <= 1'b0;
      grant_src_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      cmd_word_reg   <= cmd_word_next;
      data_word_reg  <= data_word_next;
      cmd_valid_reg  <= cmd_valid_next;
      grant_src_reg  <= grant_src_next;
    end
  end

  // Registered outputs to the decoder
  always_comb begin
    cmd_word  = cmd_word_reg;
    data_word = data_word_reg;
    cmd_valid = cmd_valid_reg;
    grant_src = grant_src_reg;
    busy      = (state_reg != ST_IDLE);
  end

endmodule
